giu_ecc_err_mon: RTL and testbench

// - Parametrised ECC error monitor for GIU protected memories (RTT data, HTT ctrl, ...), NUM_CH channels.
// - Per channel: counts single-bit (correctable) and double-bit (uncorrectable) error events.
// - Drives the C/UC interrupts and a resilience correctable-error threshold fault into the CSR block.
// - Counter outputs are CSR-readable and bench-probeable.

---
 rtl/giu_ecc_err_mon.sv | 156 +++++++++++++++
 tb/tb_giu_ecc_err_mon.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/giu_ecc_err_mon.sv
// ECC error monitor: per-channel SBE/DBE saturating counters and sticky C/UC interrupts.
// GIU_ECC_ERR_MON_RESILIENCE_EN adds the aggregate cerr counter, threshold fault FSM and mission fault.
module giu_ecc_err_mon #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int THR_W  = 10,
  parameter int CERR_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        sbe_vld,
  input  logic [NUM_CH-1:0]        dbe_vld,
  input  logic                     cnt_clr,
  input  logic                     irq_c_clr,
  input  logic                     irq_uc_clr,
  input  logic [THR_W-1:0]         cerr_threshold,
  output logic [NUM_CH*CNT_W-1:0]  single_bit_count,
  output logic [NUM_CH*CNT_W-1:0]  double_bit_count,
  output logic                     irq_c,
  output logic                     irq_uc,
  output logic [CERR_W-1:0]        cerr_counter,
  output logic                     cerr_over_thres_fault,
  output logic                     mission_fault
);

  // A DBE on a channel swallows a coincident SBE on the same channel.
  logic [NUM_CH-1:0] sbe_eff;
  logic [NUM_CH-1:0] dbe_eff;
  logic              any_sbe;
  logic              any_dbe;

  assign dbe_eff = dbe_vld;
  assign sbe_eff = sbe_vld & ~dbe_vld;
  assign any_sbe = |sbe_eff;
  assign any_dbe = |dbe_eff;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] sbe_cnt_q, sbe_cnt_d, sbe_base;
      logic [CNT_W-1:0] dbe_cnt_q, dbe_cnt_d, dbe_base;

      always_comb begin
        sbe_base  = cnt_clr ? '0 : sbe_cnt_q;
        dbe_base  = cnt_clr ? '0 : dbe_cnt_q;
        sbe_cnt_d = sbe_base;
        dbe_cnt_d = dbe_base;
        if (sbe_eff[gi] && (sbe_base != {CNT_W{1'b1}})) sbe_cnt_d = sbe_base + CNT_W'(1);
        if (dbe_eff[gi] && (dbe_base != {CNT_W{1'b1}})) dbe_cnt_d = dbe_base + CNT_W'(1);
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sbe_cnt_q <= '0;
          dbe_cnt_q <= '0;
        end else begin
          sbe_cnt_q <= sbe_cnt_d;
          dbe_cnt_q <= dbe_cnt_d;
        end
      end

      assign single_bit_count[gi*CNT_W +: CNT_W] = sbe_cnt_q;
      assign double_bit_count[gi*CNT_W +: CNT_W] = dbe_cnt_q;
    end
  endgenerate

  logic irq_c_q, irq_c_d;
  logic irq_uc_q, irq_uc_d;

  // A new event in the same cycle as the W1C pulse keeps the interrupt set.
  assign irq_c_d  = any_sbe | (irq_c_q  & ~irq_c_clr);
  assign irq_uc_d = any_dbe | (irq_uc_q & ~irq_uc_clr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_c_q  <= 1'b0;
      irq_uc_q <= 1'b0;
    end else begin
      irq_c_q  <= irq_c_d;
      irq_uc_q <= irq_uc_d;
    end
  end

  assign irq_c  = irq_c_q;
  assign irq_uc = irq_uc_q;

`ifdef GIU_ECC_ERR_MON_RESILIENCE_EN
  localparam int POP_W = $clog2(NUM_CH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CNT, ST_OVER} state_e;

  logic [POP_W-1:0]  sbe_pop;
  logic [CERR_W-1:0] cerr_q, cerr_d, cerr_base;
  logic [CERR_W:0]   cerr_sum;
  logic              thr_hit;
  logic              fault_q;
  logic              mission_q, mission_d;
  state_e            state_q, state_base;

  always_comb begin
    sbe_pop = '0;
    for (int i = 0; i < NUM_CH; i++) sbe_pop = sbe_pop + POP_W'(sbe_eff[i]);
  end

  assign cerr_base = cnt_clr ? '0 : cerr_q;
  assign cerr_sum  = {1'b0, cerr_base} + (CERR_W+1)'(sbe_pop);
  assign cerr_d    = cerr_sum[CERR_W] ? {CERR_W{1'b1}} : cerr_sum[CERR_W-1:0];
  assign thr_hit   = (cerr_threshold != '0) &&
                     (cerr_d > {{(CERR_W-THR_W){1'b0}}, cerr_threshold});
  assign mission_d = mission_q | any_dbe;

  // cnt_clr restarts the FSM from IDLE, but events of the same cycle still advance it.
  assign state_base = cnt_clr ? ST_IDLE : state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      fault_q   <= 1'b0;
      cerr_q    <= '0;
      mission_q <= 1'b0;
    end else begin
      cerr_q    <= cerr_d;
      mission_q <= mission_d;
      unique case (state_base)
        ST_IDLE: begin
          state_q <= any_sbe ? ST_CNT : ST_IDLE;
          fault_q <= 1'b0;
        end
        ST_CNT: begin
          state_q <= thr_hit ? ST_OVER : ST_CNT;
          fault_q <= thr_hit;
        end
        ST_OVER: begin
          state_q <= ST_OVER;
          fault_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign cerr_counter          = cerr_q;
  assign cerr_over_thres_fault = fault_q;
  assign mission_fault         = mission_q;
`else
  logic unused_thr;
  assign unused_thr            = ^cerr_threshold;
  assign cerr_counter          = '0;
  assign cerr_over_thres_fault = 1'b0;
  assign mission_fault         = 1'b0;
`endif

endmodule

// File: tb/tb_giu_ecc_err_mon.sv
// Bench for giu_ecc_err_mon: directed + random stimulus against a cycle-level behavioural model.
// Two instances share stimulus: default widths and a CNT_W=4 instance for saturation.
module tb_giu_ecc_err_mon;

`ifdef GIU_ECC_ERR_MON_RESILIENCE_EN
  localparam bit RES = 1'b1;
`else
  localparam bit RES = 1'b0;
`endif

  localparam longint MAX_A    = 64'd4294967295;
  localparam longint MAX_B    = 64'd15;
  localparam longint CERR_MAX = 64'd65535;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  sbe_vld = '0;
  logic [1:0]  dbe_vld = '0;
  logic        cnt_clr = 1'b0;
  logic        irq_c_clr = 1'b0;
  logic        irq_uc_clr = 1'b0;
  logic [9:0]  cerr_threshold = '0;

  logic [63:0] sbc_a, dbc_a;
  logic        irq_c_a, irq_uc_a, fault_a, mission_a;
  logic [15:0] cerr_a;
  logic [7:0]  sbc_b, dbc_b;
  logic        irq_c_b, irq_uc_b, fault_b, mission_b;
  logic [15:0] cerr_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  giu_ecc_err_mon #(.NUM_CH(2), .CNT_W(32), .THR_W(10), .CERR_W(16)) dut (
    .clk(clk), .reset(reset), .sbe_vld(sbe_vld), .dbe_vld(dbe_vld),
    .cnt_clr(cnt_clr), .irq_c_clr(irq_c_clr), .irq_uc_clr(irq_uc_clr),
    .cerr_threshold(cerr_threshold),
    .single_bit_count(sbc_a), .double_bit_count(dbc_a),
    .irq_c(irq_c_a), .irq_uc(irq_uc_a), .cerr_counter(cerr_a),
    .cerr_over_thres_fault(fault_a), .mission_fault(mission_a)
  );

  giu_ecc_err_mon #(.NUM_CH(2), .CNT_W(4), .THR_W(10), .CERR_W(16)) dut4 (
    .clk(clk), .reset(reset), .sbe_vld(sbe_vld), .dbe_vld(dbe_vld),
    .cnt_clr(cnt_clr), .irq_c_clr(irq_c_clr), .irq_uc_clr(irq_uc_clr),
    .cerr_threshold(cerr_threshold),
    .single_bit_count(sbc_b), .double_bit_count(dbc_b),
    .irq_c(irq_c_b), .irq_uc(irq_uc_b), .cerr_counter(cerr_b),
    .cerr_over_thres_fault(fault_b), .mission_fault(mission_b)
  );

  // Behavioural model state: event totals, saturated per instance width.
  longint m_sa[2], m_da[2], m_sb[2], m_db[2];
  longint m_cerr;
  bit     m_irq_c, m_irq_uc, m_fault, m_mission, m_seen;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic longint sat_inc(input longint v, input longint mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_sa[c] = 0; m_da[c] = 0; m_sb[c] = 0; m_db[c] = 0;
    end
    m_cerr = 0; m_irq_c = 0; m_irq_uc = 0; m_fault = 0; m_mission = 0; m_seen = 0;
  endtask

  task automatic model_cycle();
    int n_s;
    bit got_d;
    n_s = 0;
    got_d = 0;
    if (reset) begin
      model_reset();
    end else begin
      if (cnt_clr) begin
        for (int c = 0; c < 2; c++) begin
          m_sa[c] = 0; m_da[c] = 0; m_sb[c] = 0; m_db[c] = 0;
        end
        m_cerr = 0; m_fault = 0; m_seen = 0;
      end
      for (int c = 0; c < 2; c++) begin
        if (dbe_vld[c]) begin
          m_da[c] = sat_inc(m_da[c], MAX_A);
          m_db[c] = sat_inc(m_db[c], MAX_B);
          got_d = 1;
        end else if (sbe_vld[c]) begin
          m_sa[c] = sat_inc(m_sa[c], MAX_A);
          m_sb[c] = sat_inc(m_sb[c], MAX_B);
          n_s++;
        end
      end
      m_cerr = (m_cerr + n_s > CERR_MAX) ? CERR_MAX : m_cerr + n_s;
      m_irq_c  = (n_s > 0) || (m_irq_c && !irq_c_clr);
      m_irq_uc = got_d || (m_irq_uc && !irq_uc_clr);
      if (got_d) m_mission = 1;
      // Fault needs an SBE counted in an earlier cycle since the last clear.
      if (m_seen && cerr_threshold != 0 && m_cerr > longint'(cerr_threshold)) m_fault = 1;
      if (n_s > 0) m_seen = 1;
    end
  endtask

  // Compare process: model advances on every edge, outputs checked 1 time unit later.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_cycle();
      #1;
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("sbe_cnt_ch%0d", c), longint'(sbc_a[c*32 +: 32]), m_sa[c]);
        chk($sformatf("dbe_cnt_ch%0d", c), longint'(dbc_a[c*32 +: 32]), m_da[c]);
        chk($sformatf("sbe_cnt4_ch%0d", c), longint'(sbc_b[c*4 +: 4]), m_sb[c]);
        chk($sformatf("dbe_cnt4_ch%0d", c), longint'(dbc_b[c*4 +: 4]), m_db[c]);
      end
      chk("irq_c", longint'(irq_c_a), longint'(m_irq_c));
      chk("irq_uc", longint'(irq_uc_a), longint'(m_irq_uc));
      chk("cerr_counter", longint'(cerr_a), RES ? m_cerr : 0);
      chk("cerr_fault", longint'(fault_a), RES ? longint'(m_fault) : 0);
      chk("mission_fault", longint'(mission_a), RES ? longint'(m_mission) : 0);
      chk("irq_c_w4", longint'(irq_c_b), longint'(m_irq_c));
    end
  end

  task automatic step(input logic [1:0] s, input logic [1:0] d, input logic cc,
                      input logic ic, input logic iu);
    @(negedge clk);
    sbe_vld = s; dbe_vld = d; cnt_clr = cc; irq_c_clr = ic; irq_uc_clr = iu;
    @(posedge clk);
    #2;
    sbe_vld = '0; dbe_vld = '0; cnt_clr = 1'b0; irq_c_clr = 1'b0; irq_uc_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_async_sbc", longint'(sbc_a), 0);
    chk("rst_async_mission", longint'(mission_a), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sbc", longint'(sbc_a), 0);
    chk("rst_dbc", longint'(dbc_a), 0);
    chk("rst_irq", longint'({irq_c_a, irq_uc_a, fault_a, mission_a}), 0);
    chk("rst_cerr", longint'(cerr_a), 0);
    reset = 1'b0;

    // Five SBEs on ch0.
    step(2'b01, 2'b00, 0, 0, 0);
    chk("lit_irq_c_first", longint'(irq_c_a), 1);
    chk("lit_irq_uc_first", longint'(irq_uc_a), 0);
    repeat (4) step(2'b01, 2'b00, 0, 0, 0);
    chk("lit_sbc0_5", longint'(sbc_a[31:0]), 5);
    chk("lit_sbc1_0", longint'(sbc_a[63:32]), 0);
    chk("lit_cerr_5", longint'(cerr_a), RES ? 5 : 0);

    step(2'b11, 2'b00, 0, 0, 0);
    chk("lit_sbc0_6", longint'(sbc_a[31:0]), 6);
    chk("lit_sbc1_1", longint'(sbc_a[63:32]), 1);
    chk("lit_cerr_7", longint'(cerr_a), RES ? 7 : 0);

    // DBE dominates SBE on the same channel.
    step(2'b10, 2'b10, 0, 0, 0);
    chk("lit_sbc1_dom", longint'(sbc_a[63:32]), 1);
    chk("lit_dbc1_dom", longint'(dbc_a[63:32]), 1);
    chk("lit_irq_uc", longint'(irq_uc_a), 1);
    chk("lit_mission", longint'(mission_a), RES ? 1 : 0);

    step(2'b01, 2'b00, 0, 1, 0);
    chk("lit_irq_c_setwins", longint'(irq_c_a), 1);
    step(2'b00, 2'b00, 0, 1, 0);
    chk("lit_irq_c_cleared", longint'(irq_c_a), 0);

    step(2'b01, 2'b00, 1, 0, 0);
    chk("lit_clr_cnt_sbc0", longint'(sbc_a[31:0]), 1);
    chk("lit_clr_cnt_dbc1", longint'(dbc_a[63:32]), 0);
    chk("lit_clr_irq_uc", longint'(irq_uc_a), 1);

    // Threshold 3: fault rises on the 4th SBE.
    cerr_threshold = 10'd3;
    step(2'b00, 2'b00, 1, 0, 0);
    repeat (3) step(2'b01, 2'b00, 0, 0, 0);
    chk("lit_fault_at3", longint'(fault_a), 0);
    step(2'b01, 2'b00, 0, 0, 0);
    chk("lit_fault_at4", longint'(fault_a), RES ? 1 : 0);
    chk("lit_cerr_4", longint'(cerr_a), RES ? 4 : 0);
    repeat (2) step(2'b01, 2'b00, 0, 0, 0);
    chk("lit_fault_sticky", longint'(fault_a), RES ? 1 : 0);
    step(2'b00, 2'b00, 1, 0, 0);
    chk("lit_fault_clr", longint'(fault_a), 0);
    chk("lit_sbc0_clr", longint'(sbc_a[31:0]), 0);

    // Threshold 0 disables; lowering it under the count trips the fault next cycle.
    cerr_threshold = 10'd0;
    repeat (5) step(2'b01, 2'b00, 0, 0, 0);
    chk("lit_thr0_nofault", longint'(fault_a), 0);
    cerr_threshold = 10'd2;
    step(2'b00, 2'b00, 0, 0, 0);
    chk("lit_thr_lowered", longint'(fault_a), RES ? 1 : 0);

    // DBE saturation on the narrow instance.
    cerr_threshold = 10'd0;
    step(2'b00, 2'b00, 1, 0, 0);
    repeat (20) step(2'b00, 2'b01, 0, 0, 0);
    chk("lit_dbc4_sat", longint'(dbc_b[3:0]), 15);
    chk("lit_dbc_20", longint'(dbc_a[31:0]), 20);
    chk("lit_sat_irq_uc", longint'(irq_uc_b), 1);
    step(2'b00, 2'b00, 1, 0, 0);
    chk("lit_mission_survives_clr", longint'(mission_a), RES ? 1 : 0);
    do_reset();
    chk("lit_mission_reset", longint'(mission_a), 0);

    cerr_threshold = 10'd1;
    repeat (10) step(2'b01, 2'b00, 0, 0, 0);
    chk("lit_sbc0_10", longint'(sbc_a[31:0]), 10);
    chk("lit_cerr_10", longint'(cerr_a), RES ? 10 : 0);
    chk("lit_fault_10", longint'(fault_a), RES ? 1 : 0);

    // Reset mid-cycle with an event pending: nothing survives.
    @(negedge clk);
    sbe_vld = 2'b11;
    #2;
    reset = 1'b1;
    #1;
    chk("lit_async_sbc0", longint'(sbc_a[31:0]), 0);
    chk("lit_async_irq_c", longint'(irq_c_a), 0);
    @(negedge clk);
    sbe_vld = '0;
    reset = 1'b0;
    step(2'b00, 2'b00, 0, 0, 0);
    chk("lit_async_after", longint'(sbc_a[31:0]), 0);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset      = ($urandom_range(0, 499) == 0);
      sbe_vld    = 2'($urandom_range(0, 3));
      dbe_vld    = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
      cnt_clr    = ($urandom_range(0, 63) == 0);
      irq_c_clr  = ($urandom_range(0, 15) == 0);
      irq_uc_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 99) == 0) cerr_threshold = 10'($urandom_range(0, 40));
    end
    @(negedge clk);
    reset = 1'b0; sbe_vld = '0; dbe_vld = '0; cnt_clr = 1'b0;
    irq_c_clr = 1'b0; irq_uc_clr = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
